// File: rtl/keyboard_pkg.sv
// rtl/keyboard_pkg.sv - scancodes, port IDs and state/class encodings for the keyboard entry controller
package keyboard_pkg;

   // prefix bytes
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   // register select keys
   localparam logic [7:0] SC_F1 = 8'h05;
   localparam logic [7:0] SC_F2 = 8'h06;
   localparam logic [7:0] SC_F3 = 8'h04;
   localparam logic [7:0] SC_F4 = 8'h0C;
   localparam logic [7:0] SC_F5 = 8'h03;
   localparam logic [7:0] SC_F6 = 8'h0B;

   // command keys
   localparam logic [7:0] SC_F11   = 8'h78;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_BKSP  = 8'h66;

   // digit keys 0..9
   localparam logic [7:0] SC_D0 = 8'h45;
   localparam logic [7:0] SC_D1 = 8'h16;
   localparam logic [7:0] SC_D2 = 8'h1E;
   localparam logic [7:0] SC_D3 = 8'h26;
   localparam logic [7:0] SC_D4 = 8'h25;
   localparam logic [7:0] SC_D5 = 8'h2E;
   localparam logic [7:0] SC_D6 = 8'h36;
   localparam logic [7:0] SC_D7 = 8'h3D;
   localparam logic [7:0] SC_D8 = 8'h3E;
   localparam logic [7:0] SC_D9 = 8'h46;

   // default PicoBlaze port map and immediate direction
   localparam logic [7:0] DEF_PORT_DIR = 8'h05;
   localparam logic [7:0] DEF_PORT_DAT = 8'h06;
   localparam logic [7:0] DEF_PORT_CMT = 8'h07;
   localparam logic [7:0] DEF_IMM_DIR  = 8'h0B;

   // commit register values: bit0 pending, bit1 immediate
   localparam logic [7:0] CMT_PENDING   = 8'h01;
   localparam logic [7:0] CMT_IMMEDIATE = 8'h03;

   typedef enum logic [1:0] {
      E_SEL  = 2'd0,
      E_DAT  = 2'd1,
      E_PEND = 2'd2
   } entry_state_t;

   typedef enum logic [1:0] {
      P_IDLE  = 2'd0,
      P_BREAK = 2'd1,
      P_EXT   = 2'd2
   } prefix_state_t;

   typedef enum logic [2:0] {
      K_NONE   = 3'd0,
      K_SELECT = 3'd1,
      K_DIGIT  = 3'd2,
      K_ENTER  = 3'd3,
      K_IMM    = 3'd4,
      K_CLEAR  = 3'd5
   } key_class_t;

endpackage

// File: rtl/keyboard_scancode_classifier.sv
// rtl/keyboard_scancode_classifier.sv - combinational scancode to key class and value
module keyboard_scancode_classifier
   import keyboard_pkg::*;
(
   input  logic [7:0] code,
   output key_class_t key_class,
   output logic [3:0] value
);

   // value is the select index (1..6) or the digit (0..9); zero for other classes
   always_comb begin
      key_class = K_NONE;
      value     = 4'h0;
      case (code)
         SC_F1:    begin key_class = K_SELECT; value = 4'd1; end
         SC_F2:    begin key_class = K_SELECT; value = 4'd2; end
         SC_F3:    begin key_class = K_SELECT; value = 4'd3; end
         SC_F4:    begin key_class = K_SELECT; value = 4'd4; end
         SC_F5:    begin key_class = K_SELECT; value = 4'd5; end
         SC_F6:    begin key_class = K_SELECT; value = 4'd6; end
         SC_D0:    begin key_class = K_DIGIT;  value = 4'd0; end
         SC_D1:    begin key_class = K_DIGIT;  value = 4'd1; end
         SC_D2:    begin key_class = K_DIGIT;  value = 4'd2; end
         SC_D3:    begin key_class = K_DIGIT;  value = 4'd3; end
         SC_D4:    begin key_class = K_DIGIT;  value = 4'd4; end
         SC_D5:    begin key_class = K_DIGIT;  value = 4'd5; end
         SC_D6:    begin key_class = K_DIGIT;  value = 4'd6; end
         SC_D7:    begin key_class = K_DIGIT;  value = 4'd7; end
         SC_D8:    begin key_class = K_DIGIT;  value = 4'd8; end
         SC_D9:    begin key_class = K_DIGIT;  value = 4'd9; end
         SC_ENTER: key_class = K_ENTER;
         SC_F11:   key_class = K_IMM;
         SC_BKSP:  key_class = K_CLEAR;
         default:  key_class = K_NONE;
      endcase
   end

endmodule

// File: rtl/keyboard_entry_controller.sv
// rtl/keyboard_entry_controller.sv - PS/2 scancode to PicoBlaze register-select/BCD/commit entry
module keyboard_entry_controller
   import keyboard_pkg::*;
#(
   parameter logic [7:0] PORT_DIR = DEF_PORT_DIR,
   parameter logic [7:0] PORT_DAT = DEF_PORT_DAT,
   parameter logic [7:0] PORT_CMT = DEF_PORT_CMT,
   parameter logic [7:0] IMM_DIR  = DEF_IMM_DIR
)
(
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] Code,
   input  logic       Code_Valid,
   input  logic [7:0] Port_ID,
   input  logic       Read_Strobe,
   output logic [7:0] Keyboard_Output,
   output logic [1:0] Entry_State
);

   prefix_state_t prefix;
   entry_state_t  state, state_nx;
   logic [7:0]    dir, dat, cmt;
   logic [7:0]    dir_nx, dat_nx, cmt_nx;
   logic          seen, seen_nx;
   logic          strobe_q;
   logic [7:0]    cap_id;
   key_class_t    kclass;
   logic [3:0]    kval;
   logic          make_ev;
   logic          commit_clr;

   keyboard_scancode_classifier u_classifier (
      .code      (Code),
      .key_class (kclass),
      .value     (kval)
   );

   // a make event is any byte seen while no prefix is outstanding, other than a prefix itself
   assign make_ev    = Code_Valid && (prefix == P_IDLE) && (Code != SC_BREAK) && (Code != SC_EXT);
   // host finished reading the commit register: strobe just fell on the captured commit port
   assign commit_clr = strobe_q && !Read_Strobe && (cap_id == PORT_CMT);
   assign Entry_State = state;

   // prefix tracker keeps break/extended bytes from being taken as make events
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         prefix <= P_IDLE;
      end else if (Code_Valid) begin
         case (prefix)
            P_IDLE: begin
               if (Code == SC_BREAK)    prefix <= P_BREAK;
               else if (Code == SC_EXT) prefix <= P_EXT;
            end
            P_BREAK: prefix <= P_IDLE;
            P_EXT:   prefix <= (Code == SC_BREAK) ? P_BREAK : P_IDLE;
            default: prefix <= P_IDLE;
         endcase
      end
   end

   // next entry state: commit clear first, then the make event evaluated from the cleared state
   always_comb begin
      state_nx = state;
      dir_nx   = dir;
      dat_nx   = dat;
      cmt_nx   = cmt;
      seen_nx  = seen;
      if (commit_clr) begin
         state_nx = E_SEL;
         dir_nx   = 8'h00;
         dat_nx   = 8'h00;
         cmt_nx   = 8'h00;
         seen_nx  = 1'b0;
      end
      if (make_ev) begin
         case (state_nx)
            E_SEL, E_DAT: begin
               case (kclass)
                  K_SELECT: begin
                     dir_nx   = {4'h0, kval};
                     dat_nx   = 8'h00;
                     seen_nx  = 1'b0;
                     state_nx = E_DAT;
                  end
                  K_IMM: begin
                     dir_nx   = IMM_DIR;
                     dat_nx   = 8'h00;
                     cmt_nx   = CMT_IMMEDIATE;
                     seen_nx  = 1'b0;
                     state_nx = E_PEND;
                  end
                  K_DIGIT: begin
                     if (state_nx == E_DAT) begin
                        dat_nx  = {dat_nx[3:0], kval};
                        seen_nx = 1'b1;
                     end
                  end
                  K_ENTER: begin
                     if (state_nx == E_DAT && seen_nx) begin
                        cmt_nx   = CMT_PENDING;
                        state_nx = E_PEND;
                     end
                  end
                  K_CLEAR: begin
                     if (state_nx == E_DAT) begin
                        dir_nx   = 8'h00;
                        dat_nx   = 8'h00;
                        seen_nx  = 1'b0;
                        state_nx = E_SEL;
                     end
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   // entry registers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= E_SEL;
         dir   <= 8'h00;
         dat   <= 8'h00;
         cmt   <= 8'h00;
         seen  <= 1'b0;
      end else begin
         state <= state_nx;
         dir   <= dir_nx;
         dat   <= dat_nx;
         cmt   <= cmt_nx;
         seen  <= seen_nx;
      end
   end

   // strobe edge tracking; the port is latched at the rising edge so a late Port_ID change cannot clear
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         strobe_q <= 1'b0;
         cap_id   <= 8'h00;
      end else begin
         strobe_q <= Read_Strobe;
         if (Read_Strobe && !strobe_q) cap_id <= Port_ID;
      end
   end

   // registered read mux, one cycle latency, returns pre-clear values during the strobe
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         Keyboard_Output <= 8'h00;
      end else begin
         if (Port_ID == PORT_DIR)      Keyboard_Output <= dir;
         else if (Port_ID == PORT_DAT) Keyboard_Output <= dat;
         else if (Port_ID == PORT_CMT) Keyboard_Output <= cmt;
         else                          Keyboard_Output <= 8'h00;
      end
   end

endmodule

// File: doc/keyboard_entry_controller.md
Name: keyboard_entry_controller

Overview:
- Sequences decoded PS/2 scancodes into a host-readable command entry: register select, BCD value, commit.
- Sits between the PS/2 frame receiver (byte + valid pulse) and the PicoBlaze input port.
- Exposes three read ports (Dir/Dat/Commit) and clears the entry when the host reads Commit.

Parameters:
PORT_DIR, 8'h05, Port_ID of direction/address register
PORT_DAT, 8'h06, Port_ID of BCD data register
PORT_CMT, 8'h07, Port_ID of commit/status register
IMM_DIR, 8'h0B, direction value loaded by the F11 immediate command

Ports:
CLK  in  1  system clock, 100 MHz
RESET  in  1  asynchronous, active-low reset
Code  in  8  received scancode byte from PS/2 receiver
Code_Valid  in  1  one-cycle pulse, Code valid
Port_ID  in  8  PicoBlaze port address
Read_Strobe  in  1  PicoBlaze read strobe; may stay high for several cycles
Keyboard_Output  out  8  registered read data to PicoBlaze
Entry_State  out  2  current entry state, for debug LEDs

Behaviour:
- Reset (RESET=0, async): dir=00, dat=00, cmt=00, prefix FSM=P_IDLE, entry FSM=E_SEL, Keyboard_Output=00, Entry_State=0.
- Prefix FSM (advances only on Code_Valid):
  - P_IDLE: F0 -> P_BREAK; E0 -> P_EXT; other codes -> make event, stay.
  - P_BREAK: next byte discarded -> P_IDLE.
  - P_EXT: F0 -> P_BREAK; other byte discarded -> P_IDLE. Extended keys are unused.
- Key classes (make events only):
  - Select: F1=05, F2=06, F3=04, F4=0C, F5=03, F6=0B -> dir 01..06.
  - Digit: 45,16,1E,26,25,2E,36,3D,3E,46 -> 0..9.
  - Enter: 5A. Immediate: F11=78. Clear: Backspace=66.
  - All other codes are ignored.
- Entry FSM:
  - E_SEL (0):
    - Select: load dir, dat=00 -> E_DAT.
    - Immediate: dir=IMM_DIR, dat=00, cmt=03 -> E_PEND.
    - Other classes ignored.
  - E_DAT (1):
    - Digit: dat={dat[3:0],digit}; the third and later digits shift out the oldest nibble.
    - Select: reload dir, dat=00.
    - Enter: cmt=01 -> E_PEND only if at least one digit was entered; otherwise ignored.
    - Backspace: dir=dat=00 -> E_SEL.
    - Immediate: same as in E_SEL.
  - E_PEND (2): all make events ignored; the prefix FSM keeps tracking so break codes stay aligned.
- cmt bit map: bit0 = commit pending, bit1 = immediate, bits7:2 = 0.
- Read path:
  - Every cycle, Keyboard_Output <= (Port_ID==PORT_DIR ? dir : Port_ID==PORT_DAT ? dat : Port_ID==PORT_CMT ? cmt : 00). Latency is 1 cycle.
  - Reads of Dir and Dat have no side effect.
- Commit clear:
  - Capture Port_ID on the Read_Strobe rising edge.
  - On the falling edge (registered strobe=1, Read_Strobe=0), if the captured ID==PORT_CMT: dir, dat, cmt <= 00 and entry FSM -> E_SEL.
  - The value returned during the strobe is therefore the pre-clear value.
  - A commit read with cmt=00 still clears dir/dat and returns to E_SEL.
- Simultaneous clear and make event: clear applies first; the make event is then evaluated from E_SEL in the same cycle.
- Code_Valid while RESET=0 is ignored.

Decomposition:
- Package keyboard_pkg holds: scancode constants (F0, E0, F1-F6, F11, digits, Enter, Backspace), default port IDs, entry-state and prefix-state encodings, key-class encoding.
- Sub-module keyboard_scancode_classifier: combinational Code -> {class, value[3:0]}. It is instantiated once; the FSMs and read path stay in the top.

Test Plan:
- Reset with no keys; read 05/06/07 -> Keyboard_Output 00/00/00; Entry_State=0.
- Code 78, F0, 78 -> read 05=0B, 06=00, 07=03; after the 07 strobe falls, reread 05/06/07 -> 00/00/00.
- Each key sent as make, F0, make: 05, 1E, 16, 5A -> 05=01, 06=21, 07=01; break bytes must not create extra digits.
- 05, 16, 1E, 26, 5A -> 06=23 (oldest digit shifted out). A further 0C, 16 while pending -> no change; 07 read -> all 00.
- Edge cases:
  - 5A in E_SEL -> no change.
  - 06 then 5A with no digit -> cmt stays 00.
  - 06, 16, 66 -> dir=dat=00, Entry_State=0.
  - E0, 05 -> ignored.
- Abort: assert RESET=0 mid-entry (after 05, 16) -> all outputs 00 immediately (async); the next entry 05, 1E, 5A gives 01/02/01.
